mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It latches the execute-to-memory bus and takes the synchronous data-SRAM read data returned one cycle after the execute stage issued the access. It performs load byte/half/unaligned extraction and produces the write-back bus with a per-byte register-write strobe. It also exports exception status for exception-driven squash in the execute stage, and a forwarding bus for the decode stage.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ws_allowin` in 1: write-back stage can accept.
- `ms_allowin` out 1: this stage can accept.
- `es_to_ms_valid` in 1: execute stage presents an instruction.
- `es_to_ms_bus` in 161: {ex[160], exccode[159:155], bd[154], badvaddr[153:122], eret[121], mtc0[120], cp0_addr[119:112], cp0_wdata[111:80], res_from_cp0[79], res_from_mem[78], addr_low[77:76], lb[75], lbu[74], lh[73], lhu[72], lwl[71], lwr[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- `data_sram_rdata` in 32: word read; valid only in the first cycle after the instruction enters this stage.
- `ms_to_ws_valid` out 1: instruction is ready for write-back.
- `ms_to_ws_bus` out 156: {ex[155], exccode[154:150], bd[149], badvaddr[148:117], eret[116], mtc0[115], cp0_addr[114:107], cp0_wdata[106:75], res_from_cp0[74], rf_wstrb[73:70], dest[69:65], final_result[64:33], gr_we[32], pc[31:0]}.
- `ms_ex` out 1: valid instruction in this stage carries an exception or eret.
- `handle_ex` in 1: flush request from write-back/CP0.
- `ms_fwd_bus` out 39: {fwd_valid[38], is_load_or_cp0[37], dest[36:32], final_result[31:0]}. `fwd_valid` = ms_valid & gr_we & dest≠0.

## Operation
- Handshake:
  - `ms_ready_go` = 1.
  - `ms_allowin` = !ms_valid | (ms_ready_go & ws_allowin).
  - `ms_to_ws_valid` = ms_valid & ms_ready_go.
- Valid register, in priority order:
  - reset → 0.
  - handle_ex → 0.
  - ms_allowin → es_to_ms_valid.
- Bus register: loads `es_to_ms_bus` when es_to_ms_valid & ms_allowin.
- Read-data hold:
  - `ms_first` is set on the same enabling condition as the bus register, and cleared otherwise.
  - `rdata_buf` captures `data_sram_rdata` while ms_first=1.
  - Effective rdata = ms_first ? data_sram_rdata : rdata_buf. A load stalled by ws_allowin=0 therefore keeps its data.
- Load extraction (a = addr_low, d = effective rdata):
  - lb/lbu: byte d[8a+7:8a], sign- or zero-extended. lh/lhu: half d[16a[1]+15:16a[1]], extended likewise. Otherwise (lw): d.
  - lwl: a=0 → {d[7:0],24'b0}, strb 1000; a=1 → {d[15:0],16'b0}, 1100; a=2 → {d[23:0],8'b0}, 1110; a=3 → d, 1111.
  - lwr: a=0 → d, 1111; a=1 → {8'b0,d[31:8]}, 0111; a=2 → {16'b0,d[31:16]}, 0011; a=3 → {24'b0,d[31:24]}, 0001.
- final_result = res_from_mem ? extracted : alu_result. For res_from_cp0, final_result is alu_result; write-back substitutes the CP0 value.
- rf_wstrb:
  - 0000 when !gr_we or ex.
  - lwl/lwr values per the table above.
  - 1111 otherwise.
- ms_ex = ms_valid & (ex | eret). Exception fields pass through unchanged.
- is_load_or_cp0 = res_from_mem | res_from_cp0. Decode uses it to stall; the forwarded data is still correct.

## Timing
- Reset values:
  - ms_valid=0, ms_first=0, bus register=0, rdata_buf=0.
  - Hence ms_allowin=1, ms_to_ws_valid=0, ms_ex=0, ms_fwd_bus=0.
- Latency: 1 cycle from acceptance to ms_to_ws_valid. Fully combinational from the register to the outputs.
- Back-to-back accept with ws_allowin=1: throughput 1 per cycle, and ms_first stays 1 every cycle.
- handle_ex with a simultaneous incoming valid: valid clears and flush wins. The bus register may still load, which is harmless.
- Stall then release: result uses rdata_buf, which matches the first-cycle data even if data_sram_rdata changes.
- Asynchronous reset mid-stall: all state clears immediately, with no wait for a clock edge.

## Test plan
- Reset held low, then released: ms_allowin=1, ms_to_ws_valid=0, and ms_fwd_bus=0 throughout.
- Enter lb with addr_low=2 and rdata=0x12_8A_34_56, ws_allowin=1: next cycle final_result=0xFFFFFF8A, rf_wstrb=1111. Same with lbu: 0x0000008A.
- Enter lwl with a=1 and rdata=0xAABBCCDD: final_result=0xCCDD0000, strb=1100. Then lwr with a=2: final_result=0x0000AABB, strb=0011.
- Enter lw with rdata=0xDEADBEEF, ws_allowin=0 for 3 cycles, rdata changes to 0 after the first cycle: on release, final_result=0xDEADBEEF.
- Instruction with ex=1, gr_we=1: ms_ex=1, rf_wstrb=0000. Then assert handle_ex: ms_valid=0 next cycle.
- Assert resetn=0 asynchronously while a stalled load is held: ms_to_ws_valid drops before the next clock edge.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; latches the execute bus, holds SRAM read data across stalls,
// extracts load bytes/halves/unaligned words and builds the write-back and forwarding buses.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [160:0] es_to_ms_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic         ms_to_ws_valid,
  output logic [155:0] ms_to_ws_bus,
  output logic         ms_ex,
  input  logic         handle_ex,
  output logic [38:0]  ms_fwd_bus
);
  logic         r_valid;
  logic         r_first;
  logic [160:0] r_bus;
  logic [31:0]  r_rdata_buf;
  logic         w_ready_go;
  logic         w_accept;
  logic         w_ex;
  logic [4:0]   w_exccode;
  logic         w_bd;
  logic [31:0]  w_badvaddr;
  logic         w_eret;
  logic         w_mtc0;
  logic [7:0]   w_cp0_addr;
  logic [31:0]  w_cp0_wdata;
  logic         w_res_from_cp0;
  logic         w_res_from_mem;
  logic [1:0]   w_a;
  logic         w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr;
  logic         w_gr_we;
  logic [4:0]   w_dest;
  logic [31:0]  w_alu_result;
  logic [31:0]  w_pc;
  logic [31:0]  w_d;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [31:0]  w_mem;
  logic [31:0]  w_final;
  logic [3:0]   w_wstrb;

  assign {w_ex, w_exccode, w_bd, w_badvaddr, w_eret, w_mtc0, w_cp0_addr, w_cp0_wdata,
          w_res_from_cp0, w_res_from_mem, w_a, w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr,
          w_gr_we, w_dest, w_alu_result, w_pc} = r_bus;

  assign w_ready_go     = 1'b1;
  assign ms_allowin     = !r_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_valid && w_ready_go;
  assign w_accept       = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_first     <= 1'b0;
      r_bus       <= '0;
      r_rdata_buf <= '0;
    end else begin
      r_valid <= handle_ex ? 1'b0 : ms_allowin ? es_to_ms_valid : r_valid;
      r_first <= w_accept;
      if (w_accept) r_bus <= es_to_ms_bus;
      if (r_first) r_rdata_buf <= data_sram_rdata;
    end
  end

  // SRAM data is only live in the first cycle; afterwards the captured copy stands in
  assign w_d    = r_first ? data_sram_rdata : r_rdata_buf;
  assign w_byte = w_d[{w_a, 3'b000} +: 8];
  assign w_half = w_d[{w_a[1], 4'b0000} +: 16];

  always_comb begin
    w_mem   = w_lb  ? {{24{w_byte[7]}}, w_byte} :
              w_lbu ? {24'b0, w_byte} :
              w_lh  ? {{16{w_half[15]}}, w_half} :
              w_lhu ? {16'b0, w_half} :
              w_lwl ? w_d << {~w_a, 3'b000} :
              w_lwr ? w_d >> {w_a, 3'b000} : w_d;
    w_final = w_res_from_mem ? w_mem : w_alu_result;
    w_wstrb = (!w_gr_we || w_ex) ? 4'b0000 :
              w_lwl ? 4'b1111 << ~w_a :
              w_lwr ? 4'b1111 >> w_a : 4'b1111;
  end

  assign ms_to_ws_bus = {w_ex, w_exccode, w_bd, w_badvaddr, w_eret, w_mtc0, w_cp0_addr, w_cp0_wdata,
                         w_res_from_cp0, w_wstrb, w_dest, w_final, w_gr_we, w_pc};
  assign ms_ex        = r_valid && (w_ex || w_eret);
  assign ms_fwd_bus   = {r_valid && w_gr_we && (w_dest != 5'd0), w_res_from_mem || w_res_from_cp0,
                         w_dest, w_final};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a lane-level load model.
module tb_mem_stage;
  typedef struct packed {
    logic ex; logic [4:0] exccode; logic bd; logic [31:0] badv; logic eret; logic mtc0;
    logic [7:0] cp0a; logic [31:0] cp0w; logic rcp0; logic rmem; logic [1:0] a;
    logic lb; logic lbu; logic lh; logic lhu; logic lwl; logic lwr; logic gr_we;
    logic [4:0] dest; logic [31:0] alu; logic [31:0] pc;
  } es_t;
  typedef struct packed {
    logic ex; logic [4:0] exccode; logic bd; logic [31:0] badv; logic eret; logic mtc0;
    logic [7:0] cp0a; logic [31:0] cp0w; logic rcp0; logic [3:0] wstrb; logic [4:0] dest;
    logic [31:0] res; logic gr_we; logic [31:0] pc;
  } ws_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [160:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [155:0] ms_to_ws_bus;
  logic         ms_ex;
  logic         handle_ex;
  logic [38:0]  ms_fwd_bus;

  int n_vec = 0;
  int n_err = 0;

  logic        m_valid, m_first;
  es_t         m_bus;
  logic [31:0] m_rdata;
  ws_t         o;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ms_ex(ms_ex), .handle_ex(handle_ex), .ms_fwd_bus(ms_fwd_bus)
  );

  always #5 clk = ~clk;
  assign o = ms_to_ws_bus;

  task automatic check(input string tag, input logic [155:0] got, input logic [155:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ws_t model(input es_t b, input logic [31:0] d);
    logic [7:0]  by [4];
    logic [15:0] h;
    logic [31:0] r;
    logic [3:0]  s;
    ws_t w;
    int a;
    a = int'(b.a);
    for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
    r = b.alu;
    if (b.rmem) begin
      if (b.lb || b.lbu) r = {{24{b.lb & by[a][7]}}, by[a]};
      else if (b.lh || b.lhu) begin
        h = {by[2*(a/2)+1], by[2*(a/2)]};
        r = {{16{b.lh & h[15]}}, h};
      end else if (b.lwl) begin
        r = '0;
        for (int k = 0; k < 4; k++) if (k >= 3 - a) r[8*k +: 8] = by[k-3+a];
      end else if (b.lwr) begin
        r = '0;
        for (int k = 0; k < 4; k++) if (k <= 3 - a) r[8*k +: 8] = by[k+a];
      end else r = d;
    end
    s = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (b.lwl) s[k] = (k >= 3 - a);
      if (b.lwr) s[k] = (k <= 3 - a);
    end
    if (!b.gr_we || b.ex) s = 4'h0;
    w = '{ex: b.ex, exccode: b.exccode, bd: b.bd, badv: b.badv, eret: b.eret, mtc0: b.mtc0,
          cp0a: b.cp0a, cp0w: b.cp0w, rcp0: b.rcp0, wstrb: s, dest: b.dest, res: r,
          gr_we: b.gr_we, pc: b.pc};
    return w;
  endfunction

  function automatic es_t rand_bus();
    es_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    {b.lb, b.lbu, b.lh, b.lhu, b.lwl, b.lwr} = '0;
    b.ex   = ($urandom % 8) == 0;
    b.eret = ($urandom % 8) == 0;
    b.rmem = $urandom % 2;
    b.rcp0 = !b.rmem && (($urandom % 4) == 0);
    if (b.rmem)
      case ($urandom % 7)
        1: b.lb = 1'b1;
        2: b.lbu = 1'b1;
        3: b.lh = 1'b1;
        4: b.lhu = 1'b1;
        5: b.lwl = 1'b1;
        6: b.lwr = 1'b1;
        default: ;
      endcase
    return b;
  endfunction

  function automatic es_t load_bus(input int kind, input logic [1:0] a);
    es_t b;
    b = '0;
    b.rmem = 1'b1; b.gr_we = 1'b1; b.dest = 5'd7; b.a = a; b.alu = 32'h1000_0000 | 32'(a);
    b.pc = 32'hBFC0_0100;
    case (kind)
      1: b.lb = 1'b1;
      2: b.lbu = 1'b1;
      5: b.lwl = 1'b1;
      6: b.lwr = 1'b1;
      default: ;
    endcase
    return b;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_first = 1'b0; m_bus = '0; m_rdata = '0;
  endtask

  // inputs are set just after a negedge; checks mid-cycle, advances the model at posedge
  task automatic step();
    logic allow, acc;
    ws_t e;
    if (m_first) m_rdata = data_sram_rdata;
    #1;
    allow = !m_valid || ws_allowin;
    e = model(m_bus, m_rdata);
    check("allowin", 156'(ms_allowin), 156'(allow));
    check("to_ws_valid", 156'(ms_to_ws_valid), 156'(m_valid));
    check("ms_ex", 156'(ms_ex), 156'(m_valid && (m_bus.ex || m_bus.eret)));
    check("fwd_bus", 156'(ms_fwd_bus),
          156'({m_valid && m_bus.gr_we && (m_bus.dest != 0), m_bus.rmem || m_bus.rcp0, m_bus.dest, e.res}));
    if (m_valid) check("ws_bus", ms_to_ws_bus, e);
    @(posedge clk);
    acc = es_to_ms_valid && allow;
    m_valid = handle_ex ? 1'b0 : allow ? es_to_ms_valid : m_valid;
    if (acc) m_bus = es_to_ms_bus;
    m_first = acc;
    @(negedge clk);
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0; handle_ex = 1'b0; ws_allowin = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; idle(); es_to_ms_bus = '0; data_sram_rdata = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_allowin", 156'(ms_allowin), 156'(1));
      check("rst_valid", 156'(ms_to_ws_valid), 156'(0));
      check("rst_fwd", 156'(ms_fwd_bus), 156'(0));
    end
    resetn = 1'b1;
    step();

    es_to_ms_valid = 1'b1; es_to_ms_bus = load_bus(1, 2'd2); step();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'h128A_3456; #1;
    check("lb_res", 156'(o.res), 156'(32'hFFFF_FF8A));
    check("lb_strb", 156'(o.wstrb), 156'(4'b1111));
    es_to_ms_valid = 1'b1; es_to_ms_bus = load_bus(2, 2'd2); step();
    es_to_ms_valid = 1'b0; #1;
    check("lbu_res", 156'(o.res), 156'(32'h0000_008A));
    es_to_ms_valid = 1'b1; es_to_ms_bus = load_bus(5, 2'd1); step();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'hAABB_CCDD; #1;
    check("lwl_res", 156'(o.res), 156'(32'hCCDD_0000));
    check("lwl_strb", 156'(o.wstrb), 156'(4'b1100));
    es_to_ms_valid = 1'b1; es_to_ms_bus = load_bus(6, 2'd2); step();
    es_to_ms_valid = 1'b0; #1;
    check("lwr_res", 156'(o.res), 156'(32'h0000_AABB));
    check("lwr_strb", 156'(o.wstrb), 156'(4'b0011));
    step();

    es_to_ms_valid = 1'b1; es_to_ms_bus = load_bus(0, 2'd0); step();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; step();
    data_sram_rdata = 32'h0; step(); step();
    ws_allowin = 1'b1; #1;
    check("stall_res", 156'(o.res), 156'(32'hDEAD_BEEF));
    step();

    es_to_ms_bus = load_bus(0, 2'd0);
    es_to_ms_bus[160] = 1'b1;
    es_to_ms_valid = 1'b1; step();
    es_to_ms_valid = 1'b0; #1;
    check("ex_flag", 156'(ms_ex), 156'(1));
    check("ex_strb", 156'(o.wstrb), 156'(4'b0000));
    handle_ex = 1'b1; ws_allowin = 1'b0; step();
    handle_ex = 1'b0; ws_allowin = 1'b1; #1;
    check("flush_valid", 156'(ms_to_ws_valid), 156'(0));
    step();

    es_to_ms_valid = 1'b1; es_to_ms_bus = load_bus(0, 2'd0); step();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; step();
    #1 check("held_valid", 156'(ms_to_ws_valid), 156'(1));
    resetn = 1'b0;
    #1 check("async_rst_valid", 156'(ms_to_ws_valid), 156'(0));
    check("async_rst_allowin", 156'(ms_allowin), 156'(1));
    model_reset();
    @(negedge clk);
    resetn = 1'b1; idle(); step();

    for (int i = 0; i < 400; i++) begin
      es_to_ms_valid  = ($urandom % 4) != 0;
      ws_allowin      = ($urandom % 3) != 0;
      handle_ex       = ($urandom % 12) == 0;
      data_sram_rdata = $urandom;
      es_to_ms_bus    = rand_bus();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
